regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back arbiter that owns the single register-file write port (we/wAddr/wData). It merges the single-cycle ALU result stream with long-latency results (load/mul-div) through a small FIFO. It keeps a 32-entry pending scoreboard so decode can stall on registers whose long-latency result has not yet been written. It sits between the execute/memory stages and the register file, as the writer for that file.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)
STARVE_MAX, 8, consecutive cycles the FIFO may be full and blocked by the ALU before the ALU is stalled

Ports:
clk  in  1  clock
rst  in  1  reset
alu_valid  in  1  ALU result present this cycle
alu_addr  in  5  ALU destination register
alu_data  in  32  ALU result
alu_stall  out  1  ALU result not accepted this cycle; upstream holds it
long_valid  in  1  long-latency result offered
long_addr  in  5  long-latency destination register
long_data  in  32  long-latency result
long_ready  out  1  FIFO can accept (= !full)
issue_valid  in  1  long-latency op issued this cycle
issue_addr  in  5  its destination register
rd_a_addr  in  5  decode query address A
rd_b_addr  in  5  decode query address B
busy_a  out  1  rd_a_addr has a pending long-latency write
busy_b  out  1  rd_b_addr has a pending long-latency write
we  out  1  register-file write enable
w_addr  out  5  register-file write address
w_data  out  32  register-file write data

Behaviour:
- Reset: synchronous, active-high (rst), clock clk. While rst=1 at a clk edge: we=0, w_addr=0, w_data=0, FIFO empty (count=0, pointers=0), scoreboard all 0, starve counter=0. A reset mid-operation discards FIFO contents and pending bits with no write issued.
- Write port is registered: a source selected in cycle N appears on we/w_addr/w_data in cycle N+1 for exactly one cycle. we=0 in any cycle with no selection.
- Selection each cycle:
  - If alu_valid and alu_stall=0, the ALU wins.
  - Otherwise, if the FIFO is non-empty, pop the head.
  - Otherwise, idle.
- alu_stall=1 only when the FIFO is full, the starve counter equals STARVE_MAX, and alu_valid=1. That cycle the FIFO head is popped and the ALU result is not consumed.
- Starve counter: increments when the FIFO is full and the ALU wins. Clears on any FIFO pop or when the FIFO is not full. Saturates at STARVE_MAX.
- Address 0: a selected write with addr 0 still consumes its slot or pop, but drives we=0. issue_valid with addr 0 never sets a pending bit.
- FIFO: push when long_valid && long_ready. long_ready = (count != DEPTH), computed from the current count with no same-cycle pop credit. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH. Data is first-in, first-out.
- Scoreboard pend[31:0]:
  - Set on issue_valid (addr != 0).
  - Cleared when a FIFO entry is popped, for that entry's addr.
  - Same-cycle set and clear of the same addr: set wins.
  - ALU writes never touch pend; a WAW conflict is upstream's responsibility.
- busy_a = pend[rd_a_addr], combinational, forced 0 when rd_a_addr=0. busy_b is the same for rd_b_addr. The bit clears in the same cycle the pop is selected, so decode may issue as the write lands. The register file write-then-read ordering covers this.
- Width rules: count is $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits.

Decomposition:
- Shared package (define header):
  - REG_AW=5 and DATA_W=32.
  - Existing Valid, Zero and RstEnable/RstDisable constants are reused.
- One sub-module, wb_fifo: a parameterised synchronous FIFO with push/pop/full/empty/count, instantiated once.
- Scoreboard and arbitration logic stay in the top module.

Test Plan:
- Reset then idle: hold rst 2 cycles, then release. Required: we=0, busy_a=busy_b=0, long_ready=1.
- ALU only: alu_valid with addr=3, data=0xFFFF_FFFF. Required: next cycle we=1, w_addr=3, w_data=0xFFFF_FFFF; one cycle later we=0.
- Long path with scoreboard:
  - issue_valid addr=17 → busy_a=1 for rd_a_addr=17.
  - Push long addr=17, data=0x2 while ALU idle.
  - Required: write 17/0x2 one cycle after the pop. busy_a drops in the pop cycle.
- Contention:
  - ALU valid every cycle while 4 long results are pushed. Required: long_ready=0 after the 4th push.
  - After STARVE_MAX=8 full+ALU-win cycles, alu_stall=1 for one cycle and the head entry (FIFO order) is written.
- Address 0:
  - issue_valid addr=0 → busy stays 0.
  - FIFO entry with addr=0 popped → we=0; count decrements.
- Reset mid-operation:
  - FIFO holding 3 entries and pend[5]=1, then rst asserted.
  - Required: next cycle count=0, busy for addr 5 =0, and no write of the discarded entries after reset.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, constants and the write-back entry type
package regfile_wb_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic Valid = 1'b1;
  localparam logic Zero = 1'b0;
  localparam logic RstEnable = 1'b1;
  localparam logic RstDisable = 1'b0;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO (clk, rst, push/din, pop/dout head, full, empty, count)
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import regfile_wb_arbiter_pkg::*;
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: register-file write-port owner merging ALU and long-latency results.
// Ports: clk/rst; alu_* in with alu_stall out; long_* in with long_ready out; issue_* sets
// the pending scoreboard; rd_a/b_addr query busy_a/b; we/w_addr/w_data drive the register file.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_stall,
  input  logic              long_valid,
  input  logic [REG_AW-1:0] long_addr,
  input  logic [DATA_W-1:0] long_data,
  output logic              long_ready,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_addr,
  input  logic [REG_AW-1:0] rd_a_addr,
  input  logic [REG_AW-1:0] rd_b_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              we,
  output logic [REG_AW-1:0] w_addr,
  output logic [DATA_W-1:0] w_data
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int NR = 2 ** REG_AW;
  wb_entry_t head, sel_entry;
  logic fifo_full, fifo_empty, alu_sel, pop, sel;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [SW-1:0] starve, starve_next;
  logic [NR-1:0] pend, pend_vis, pend_next;
  wb_fifo #(.DEPTH(DEPTH), .W($bits(wb_entry_t))) u_fifo (
    .clk(clk), .rst(rst),
    .push(long_valid), .pop(pop),
    .din({long_addr, long_data}), .dout(head),
    .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  assign long_ready = !fifo_full;
  assign alu_stall = fifo_full && starve == SW'(STARVE_MAX) && alu_valid;
  assign alu_sel = alu_valid && !alu_stall;
  assign pop = !alu_sel && !fifo_empty;
  assign sel = alu_sel || pop;
  assign sel_entry = alu_sel ? wb_entry_t'({alu_addr, alu_data}) : head;
  // Popped entry's pending bit is dropped combinationally so decode sees it free as the write lands
  assign pend_vis = pend & ~(pop ? NR'(1) << head.addr : '0);
  assign pend_next = pend_vis | (issue_valid && issue_addr != '0 ? NR'(1) << issue_addr : '0);
  assign busy_a = rd_a_addr != '0 && pend_vis[rd_a_addr];
  assign busy_b = rd_b_addr != '0 && pend_vis[rd_b_addr];
  assign starve_next = (pop || fifo_count != ($clog2(DEPTH)+1)'(DEPTH)) ? '0
                     : (alu_sel && starve != SW'(STARVE_MAX)) ? starve + 1'b1 : starve;
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      we <= Zero;
      w_addr <= '0;
      w_data <= '0;
      pend <= '0;
      starve <= '0;
    end else begin
      we <= sel && sel_entry.addr != '0 ? Valid : Zero;
      w_addr <= sel_entry.addr;
      w_data <= sel_entry.data;
      pend <= pend_next;
      starve <= starve_next;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plus random stimulus checked against a queue-based model
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int STARVE_MAX = 8;
  logic clk = 0, rst = 1;
  logic alu_valid = 0, long_valid = 0, issue_valid = 0;
  logic [4:0] alu_addr = 0, long_addr = 0, issue_addr = 0, rd_a_addr = 0, rd_b_addr = 0;
  logic [31:0] alu_data = 0, long_data = 0;
  logic alu_stall, long_ready, busy_a, busy_b, we;
  logic [4:0] w_addr;
  logic [31:0] w_data;
  int checks = 0, failures = 0;
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  bit [31:0] pend;
  int starve;
  logic exp_we;
  logic [4:0] exp_wa;
  logic [31:0] exp_wd;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_stall(alu_stall),
    .long_valid(long_valid), .long_addr(long_addr), .long_data(long_data), .long_ready(long_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .busy_a(busy_a), .busy_b(busy_b),
    .we(we), .w_addr(w_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ia, input logic [4:0] ra, input logic [4:0] rb);
    bit full, stall, asel, pop;
    bit [31:0] pv;
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    long_valid = lv; long_addr = la; long_data = ld;
    issue_valid = iv; issue_addr = ia; rd_a_addr = ra; rd_b_addr = rb;
    @(negedge clk);
    full = q.size() == DEPTH;
    stall = full && starve == STARVE_MAX && av;
    asel = av && !stall;
    pop = !asel && q.size() > 0;
    pv = pend;
    if (pop) pv[q[0].a] = 1'b0;
    chk("we", {31'd0, we}, {31'd0, exp_we});
    if (exp_we) begin
      chk("w_addr", {27'd0, w_addr}, {27'd0, exp_wa});
      chk("w_data", w_data, exp_wd);
    end
    chk("alu_stall", {31'd0, alu_stall}, {31'd0, stall});
    chk("long_ready", {31'd0, long_ready}, {31'd0, !full});
    chk("busy_a", {31'd0, busy_a}, {31'd0, ra != 0 && pv[ra]});
    chk("busy_b", {31'd0, busy_b}, {31'd0, rb != 0 && pv[rb]});
    if (r) begin
      exp_we = 0; q.delete(); pend = 0; starve = 0;
    end else begin
      if (asel) begin exp_we = aa != 0; exp_wa = aa; exp_wd = ad; end
      else if (pop) begin exp_we = q[0].a != 0; exp_wa = q[0].a; exp_wd = q[0].d; end
      else exp_we = 0;
      if (pop || !full) starve = 0;
      else if (asel && starve < STARVE_MAX) starve++;
      if (pop) void'(q.pop_front());
      if (lv && !full) q.push_back('{a: la, d: ld});
      pend = pv;
      if (iv && ia != 0) pend[ia] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    exp_we = 0; pend = 0; starve = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 17, 3);
    step(0, 1, 3, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 17, 17, 0);
    step(0, 0, 0, 0, 1, 17, 32'h2, 0, 0, 17, 17);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 17, 17);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 17, 17);
    for (int i = 0; i < 4; i++) step(0, 1, 5'(i + 1), 32'(100 + i), 1, 5'(20 + i), 32'(200 + i), 1, 5'(20 + i), 20, 23);
    for (int i = 0; i < 14; i++) step(0, 1, 5'(i + 8), 32'(300 + i), 0, 0, 0, 0, 0, 20, 21);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 22, 23);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 9, 32'h9, 1, 0, 32'hDEAD, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 5, 32'h55, 1, 5, 5, 0);
    step(0, 1, 2, 2, 1, 6, 32'h66, 0, 0, 5, 0);
    step(0, 1, 3, 3, 1, 7, 32'h77, 0, 0, 5, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
